// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: latch en/flush and pc_en from cache, hazard, redirect and halt inputs.
// Optional performance counters (stall_cnt, flush_cnt) are built when PIPE_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_req,
  input  logic             idex_memRead,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic             redirect,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [1:0]       dbg_state
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  // Debug encoding of dbg_state: 0 = RUN, 1 = DWAIT, 2 = HALT.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_load_use;
  logic   w_redirect_cyc;

  assign w_load_use = idex_memRead && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  assign dbg_state = r_state;

  // Priority: reset, HALT, wb_halt, dcache miss, redirect, load-use, icache miss, normal.
  always_comb begin
    w_next         = r_state;
    w_redirect_cyc = 1'b0;
    pc_en          = 1'b0;
    ifid_en        = 1'b0;
    idex_en        = 1'b0;
    exmem_en       = 1'b0;
    memwb_en       = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    memwb_flush    = 1'b0;
    halted         = 1'b0;
    if (!nRST) begin
      w_next      = ST_RUN;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (r_state == ST_HALT) begin
      halted = 1'b1;
    end else if (wb_halt) begin
      w_next = ST_HALT;
    end else if (mem_req && !dhit) begin
      // Only WB moves, and it takes a bubble so the stalled MEM result is not written twice.
      w_next      = ST_DWAIT;
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else begin
      w_next   = ST_RUN;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (redirect) begin
        w_redirect_cyc = 1'b1;
        pc_en          = 1'b1;
        ifid_en        = 1'b1;
        idex_en        = 1'b1;
        ifid_flush     = 1'b1;
        idex_flush     = 1'b1;
      end else if (w_load_use) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Counters saturate at all-ones and freeze once halted.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ST_HALT) begin
      if (!pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_redirect_cyc && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-table model.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  // Model rule classes, in priority order.
  localparam int R_RESET    = 0;
  localparam int R_HALTED   = 1;
  localparam int R_HALTREQ  = 2;
  localparam int R_DMISS    = 3;
  localparam int R_REDIR    = 4;
  localparam int R_LOADUSE  = 5;
  localparam int R_IMISS    = 6;
  localparam int R_NORMAL   = 7;

  // Stage actions.
  localparam int A_HOLD = 0;
  localparam int A_ADV  = 1;
  localparam int A_BUB  = 2;

  logic             clk;
  logic             nRST;
  logic             ihit;
  logic             dhit;
  logic             mem_req;
  logic             idex_memRead;
  logic [REG_W-1:0] idex_rd;
  logic [REG_W-1:0] ifid_rs1;
  logic [REG_W-1:0] ifid_rs2;
  logic             redirect;
  logic             wb_halt;
  logic             pc_en;
  logic             ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             halted;
  logic [1:0]       dbg_state;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Model state: mode 0 = running, 1 = waiting on dcache, 2 = halted.
  int               m_mode = 0;
  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  logic [9:0] dut_vec;
  assign dut_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush, halted};

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK          (clk),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_req      (mem_req),
    .idex_memRead (idex_memRead),
    .idex_rd      (idex_rd),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .redirect     (redirect),
    .wb_halt      (wb_halt),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .exmem_flush  (exmem_flush),
    .memwb_flush  (memwb_flush),
    .halted       (halted),
    .dbg_state    (dbg_state)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- model ----------------
  function automatic int classify(int mode, logic rst_n, logic ih, logic dh, logic mr,
                                  logic lr, logic [REG_W-1:0] rd, logic [REG_W-1:0] s1,
                                  logic [REG_W-1:0] s2, logic rdir, logic wh);
    if (!rst_n) return R_RESET;
    if (mode == 2) return R_HALTED;
    if (wh) return R_HALTREQ;
    if (mr && !dh) return R_DMISS;
    if (rdir) return R_REDIR;
    if (lr && rd != 0 && (rd == s1 || rd == s2)) return R_LOADUSE;
    if (!ih) return R_IMISS;
    return R_NORMAL;
  endfunction

  function automatic logic [9:0] rule_outputs(int rule);
    int act[4];
    logic pc;
    logic [9:0] v;
    if (rule == R_RESET) return 10'b0_0000_1111_0;
    if (rule == R_HALTED) return 10'b0_0000_0000_1;
    pc = 1'b0;
    for (int i = 0; i < 4; i++) act[i] = A_ADV;
    case (rule)
      R_HALTREQ: for (int i = 0; i < 4; i++) act[i] = A_HOLD;
      R_DMISS: begin
        for (int i = 0; i < 3; i++) act[i] = A_HOLD;
        act[3] = A_BUB;
      end
      R_REDIR: begin pc = 1'b1; act[0] = A_BUB; act[1] = A_BUB; end
      R_LOADUSE: begin act[0] = A_HOLD; act[1] = A_BUB; end
      R_IMISS: act[0] = A_BUB;
      default: pc = 1'b1;
    endcase
    v[9] = pc;
    for (int i = 0; i < 4; i++) begin
      v[8-i] = (act[i] != A_HOLD);
      v[4-i] = (act[i] == A_BUB);
    end
    v[0] = 1'b0;
    return v;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int rule;
    logic [9:0] exp_v;
    rule  = classify(m_mode, nRST, ihit, dhit, mem_req, idex_memRead, idex_rd,
                     ifid_rs1, ifid_rs2, redirect, wb_halt);
    if (!nRST) begin
      m_mode  = 0;
      m_stall = '0;
      m_flush = '0;
    end
    exp_v = rule_outputs(rule);
    tests++;
    if (dut_vec !== exp_v) begin
      fails++;
      $display("FAIL cycle_outputs t=%0t rule=%0d got=%b exp=%b", $time, rule, dut_vec, exp_v);
    end
    tests++;
    if (dbg_state !== 2'(m_mode)) begin
      fails++;
      $display("FAIL cycle_state t=%0t got=%0d exp=%0d", $time, dbg_state, m_mode);
    end
`ifdef PIPE_PERF_EN
    tests++;
    if (stall_cnt !== m_stall || flush_cnt !== m_flush) begin
      fails++;
      $display("FAIL cycle_counters t=%0t got=%0d/%0d exp=%0d/%0d", $time,
               stall_cnt, flush_cnt, m_stall, m_flush);
    end
`endif
    if (nRST) begin
      if (rule != R_HALTED && !exp_v[9] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (rule == R_REDIR && m_flush != '1) m_flush = m_flush + 1'b1;
      if (rule == R_HALTED || rule == R_HALTREQ) m_mode = 2;
      else if (rule == R_DMISS) m_mode = 1;
      else m_mode = 0;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; mem_req = 1'b0; idex_memRead = 1'b0;
    idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0; redirect = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic check_lit(input string name, input logic [9:0] exp_v, input logic [1:0] exp_st);
    tests++;
    if (dut_vec !== exp_v || dbg_state !== exp_st) begin
      fails++;
      $display("FAIL %s got=%b st=%0d exp=%b st=%0d", name, dut_vec, dbg_state, exp_v, exp_st);
    end
  endtask

`ifdef PIPE_PERF_EN
  task automatic check_cnt(input string name, input int exp_s, input int exp_f);
    tests++;
    if (stall_cnt !== CNT_W'(exp_s) || flush_cnt !== CNT_W'(exp_f)) begin
      fails++;
      $display("FAIL %s got=%0d/%0d exp=%0d/%0d", name, stall_cnt, flush_cnt, exp_s, exp_f);
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    idle_inputs();

    @(negedge clk);
    check_lit("reset_outputs", 10'b0_0000_1111_0, 2'd0);
    next_cycle();
    nRST = 1'b1;
    @(negedge clk);
    check_lit("release_normal", 10'b1_1111_0000_0, 2'd0);

    // dcache miss for three cycles, then hit
    next_cycle();
    mem_req = 1'b1; dhit = 1'b0;
    @(negedge clk);
    check_lit("dmiss_1", 10'b0_0001_0001_0, 2'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      @(negedge clk);
      check_lit("dmiss_wait", 10'b0_0001_0001_0, 2'd1);
    end
    next_cycle();
    dhit = 1'b1;
    @(negedge clk);
    check_lit("dmiss_hit", 10'b1_1111_0000_0, 2'd1);
    next_cycle();
    mem_req = 1'b0;
    @(negedge clk);
    check_lit("dmiss_back_run", 10'b1_1111_0000_0, 2'd0);
`ifdef PIPE_PERF_EN
    check_cnt("dmiss_stall_cnt", 3, 0);
`endif

    // load-use on rs2, then same with rd=0
    next_cycle();
    idex_memRead = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs1 = 5'd1;
    @(negedge clk);
    check_lit("load_use", 10'b0_0111_0100_0, 2'd0);
    next_cycle();
    idex_rd = 5'd0; ifid_rs2 = 5'd0;
    @(negedge clk);
    check_lit("load_use_x0", 10'b1_1111_0000_0, 2'd0);

    // redirect beats load-use and icache miss
    next_cycle();
    idex_rd = 5'd7; ifid_rs1 = 5'd7; ihit = 1'b0; redirect = 1'b1;
    @(negedge clk);
    check_lit("redirect_combo", 10'b1_1111_1100_0, 2'd0);
    next_cycle();
    idle_inputs();
    ihit = 1'b0;
    @(negedge clk);
    check_lit("imiss", 10'b0_1111_1000_0, 2'd0);
`ifdef PIPE_PERF_EN
    check_cnt("redirect_cnt", 4, 1);
`endif

    // halt while a dcache miss is pending
    next_cycle();
    ihit = 1'b1; mem_req = 1'b1; dhit = 1'b0; wb_halt = 1'b1;
    @(negedge clk);
    check_lit("halt_request", 10'b0_0000_0000_0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      wb_halt = 1'($urandom_range(0, 1)); redirect = 1'($urandom_range(0, 1));
      mem_req = 1'($urandom_range(0, 1)); dhit = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_lit("halt_held", 10'b0_0000_0000_1, 2'd2);
    end
`ifdef PIPE_PERF_EN
    check_cnt("halt_frozen_cnt", 6, 1);
`endif

    // reset asserted during DWAIT
    next_cycle();
    idle_inputs();
    nRST = 1'b0;
    next_cycle();
    nRST = 1'b1; mem_req = 1'b1; dhit = 1'b0;
    @(negedge clk);
    check_lit("dwait_enter", 10'b0_0001_0001_0, 2'd0);
    next_cycle();
    @(negedge clk);
    check_lit("dwait_hold", 10'b0_0001_0001_0, 2'd1);
    next_cycle();
    nRST = 1'b0;
    @(negedge clk);
    check_lit("reset_in_dwait", 10'b0_0000_1111_0, 2'd0);
    next_cycle();
    nRST = 1'b1; mem_req = 1'b0; dhit = 1'b1;
    @(negedge clk);
    check_lit("release_after_dwait", 10'b1_1111_0000_0, 2'd0);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      if (m_mode == 2) nRST = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
      else             nRST = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      ihit         = ($urandom_range(0, 99) < 80);
      dhit         = ($urandom_range(0, 99) < 60);
      mem_req      = ($urandom_range(0, 99) < 40);
      idex_memRead = ($urandom_range(0, 99) < 40);
      idex_rd      = REG_W'($urandom_range(0, 7));
      ifid_rs1     = REG_W'($urandom_range(0, 7));
      ifid_rs2     = REG_W'($urandom_range(0, 7));
      redirect     = ($urandom_range(0, 99) < 10);
      wb_halt      = ($urandom_range(0, 99) < 1);
    end

    next_cycle();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
